// File: rtl/goose_pkg.sv
// Shared constants for the goose-run display pipeline: state encoding and screen geometry.
package goose_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTART = 2'd1,
        ST_RUN     = 2'd2,
        ST_HIT     = 2'd3
    } state_e;

    localparam logic [9:0] H_LAST = 10'd639;
    localparam logic [9:0] V_LAST = 10'd479;

    // Bean renderer and score are held in reset while the game is not being played.
    function automatic logic holds_game_reset(state_e st);
        return (st == ST_IDLE) || (st == ST_RESTART);
    endfunction

endpackage

// File: rtl/collision_fsm_if.sv
// Pixel stream from the renderers into the collision detector, and its control outputs back.
interface collision_fsm_if;

    logic       pix_en;
    logic [9:0] x;
    logic [9:0] y;
    logic       goose;
    logic       bean;

    logic       check_hit;
    logic       game_reset;
    logic [1:0] state;
    logic       hit_frame;

    modport master (
        output pix_en, x, y, goose, bean,
        input  check_hit, game_reset, state, hit_frame
    );

    modport slave (
        input  pix_en, x, y, goose, bean,
        output check_hit, game_reset, state, hit_frame
    );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for one raw button bit followed by a rising-edge detector.
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/collision_fsm.sv
// Per-frame goose/bean collision detector and game-state sequencer (IDLE, RESTART, RUN, HIT).
module collision_fsm
    import goose_pkg::*;
#(
    parameter int unsigned HIT_MIN      = 4,
    parameter int unsigned GRACE_FRAMES = 30
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [1:0]     button,
    collision_fsm_if.slave bus
);

    localparam logic [7:0] HitMinW = 8'(HIT_MIN);
    localparam logic [7:0] GraceW  = 8'(GRACE_FRAMES);

    logic [1:0] btn_rise;
    logic       start;
    logic       fe;
    logic       overlap_px;

    state_e     state_q, state_d;
    logic [7:0] ovl_q, ovl_d;
    logic [7:0] grace_q, grace_d;
    logic       game_reset_q;
    logic       check_hit_q;
    logic       hit_frame_q;

    for (genvar i = 0; i < 2; i++) begin : g_btn
        btn_sync_edge u_btn_sync_edge (
            .clk_i  (clk),
            .rst_ni (reset_n),
            .btn_i  (button[i]),
            .rise_o (btn_rise[i])
        );
    end

    assign start      = |btn_rise;
    assign fe         = bus.pix_en && (bus.x == H_LAST) && (bus.y == V_LAST);
    assign overlap_px = bus.pix_en && bus.goose && bus.bean;

    // The frame-end pixel itself never counts, even when it overlaps.
    always_comb begin
        ovl_d = ovl_q;
        if (fe) begin
            ovl_d = 8'd0;
        end else if (overlap_px && (ovl_q < HitMinW)) begin
            ovl_d = ovl_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RESTART;
            end
            ST_RESTART: begin
                if (fe) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (fe && (grace_q == 8'd0) && (ovl_q >= HitMinW)) state_d = ST_HIT;
            end
            ST_HIT: begin
                if (start) state_d = ST_RESTART;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grace is sampled before this edge's decrement, so the load value covers GRACE_FRAMES frames.
    always_comb begin
        grace_d = grace_q;
        if ((state_q != ST_RUN) && (state_d == ST_RUN)) begin
            grace_d = GraceW;
        end else if ((state_q == ST_RUN) && fe && (grace_q != 8'd0)) begin
            grace_d = grace_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovl_q   <= 8'd0;
            grace_q <= 8'd0;
        end else begin
            ovl_q   <= ovl_d;
            grace_q <= grace_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            game_reset_q <= 1'b1;
            check_hit_q  <= 1'b0;
            hit_frame_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            game_reset_q <= holds_game_reset(state_d);
            check_hit_q  <= (state_d == ST_HIT);
            hit_frame_q  <= (state_q == ST_RUN) && (state_d == ST_HIT);
        end
    end

    assign bus.state      = state_q;
    assign bus.game_reset = game_reset_q;
    assign bus.check_hit  = check_hit_q;
    assign bus.hit_frame  = hit_frame_q;

endmodule
